// File: rtl/tt_div_pkg.sv
// rtl/tt_div_pkg.sv - shared state encoding and width helpers for the sequential divider
package tt_div_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic logic [63:0] min_val(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Magnitude of a w-bit two's-complement value; |MIN| comes out as 2^(w-1).
    function automatic logic [63:0] abs_w(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        if (v[w-1])
            return (~v + 64'd1) & mask;
        return v & mask;
    endfunction

endpackage

// File: rtl/tt_div_step.sv
// rtl/tt_div_step.sv - one combinational restoring-division step
module tt_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;

    // The shifted remainder needs one extra bit; after the trial subtract it fits WIDTH again.
    always_comb begin
        r_sh = {r_in, q_in[WIDTH-1]};
        if (r_sh >= {1'b0, d}) begin
            r_out = WIDTH'(r_sh - {1'b0, d});
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = r_sh[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/tt_seq_divider.sv
// rtl/tt_seq_divider.sv - multi-cycle restoring divider with signed mode and start/busy/done handshake
module tt_seq_divider
    import tt_div_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(min_val(WIDTH));

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q_reg, r_reg, d_reg;
    logic [WIDTH-1:0] q_nxt, r_nxt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q, neg_r, dz, ovf;
    logic             signed_op;

    assign signed_op = SIGNED_EN & is_signed;

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        if (signed_op) begin
            a_mag = WIDTH'(abs_w(64'(dividend), WIDTH));
            b_mag = WIDTH'(abs_w(64'(divisor), WIDTH));
        end
    end

    tt_div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_reg),
        .q_in  (q_reg),
        .d     (d_reg),
        .r_out (r_nxt),
        .q_out (q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_reg <= a_mag;
                        r_reg <= '0;
                        d_reg <= b_mag;
                        cnt   <= CNT_LAST;
                        neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op & dividend[WIDTH-1];
                        dz    <= (divisor == '0);
                        ovf   <= signed_op && (dividend == MIN_V) && (divisor == '1);
                        busy  <= 1'b1;
                        state <= (divisor == '0) ? ST_FIXUP : ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_reg <= r_nxt;
                    q_reg <= q_nxt;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    overflow    <= ovf;
                    // On divide-by-zero q_reg still holds |dividend|; re-signing it restores the dividend.
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= neg_r ? -q_reg : q_reg;
                    end else begin
                        quotient  <= neg_q ? -q_reg : q_reg;
                        remainder <= neg_r ? -r_reg : r_reg;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_seq_divider.sv
// tb/tb_tt_seq_divider.sv - randomized self-checking bench for tt_seq_divider
module tb_tt_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad = 0;

    tt_seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (SV int division truncates toward zero).
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int sa, sb, iq, ir;
        dz = (b == 0);
        ov = 1'b0;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            iq = sa / sb;
            ir = sa % sb;
            q  = W'(iq);
            r  = W'(ir);
            ov = (sa == -(1 << (W - 1))) && (sb == -1);
        end else begin
            iq = int'(a) / int'(b);
            ir = int'(a) % int'(b);
            q  = W'(iq);
            r  = W'(ir);
        end
    endtask

    // Launches one op, optionally stalls ena, waits for done and checks everything.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input int stall_at, input int stall_len,
                          input logic chk_lat);
        logic [W-1:0] eq, er;
        logic         edz, eov;
        int           n;
        int           lat_exp;
        logic         busy_ok;
        model(a, b, sgn, eq, er, edz, eov);
        lat_exp = ((b == 0) ? 1 : W + 1) + stall_len;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy_ok = busy;
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == stall_at) ena = 1'b0;
            if (n == stall_at + stall_len) ena = 1'b1;
            if (done) break;
            busy_ok = busy_ok & busy;
        end
        if (!done) check({tag, "_timeout"}, 32'(n), 32'(lat_exp));
        if (chk_lat) begin
            check({tag, "_latency"}, 32'(n), 32'(lat_exp));
            check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_ovf"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        logic [W-1:0] eq, er;
        logic         edz, eov;
        logic [W-1:0] ra, rb;
        logic         rs;
        int           n;
        logic         seen_done;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u100_7", 8'd100, 8'd7, 1'b0, 0, 0, 1'b1);
        run_op("s_m7_2", 8'hF9, 8'h02, 1'b1, 0, 0, 1'b1);
        run_op("s_7_m2", 8'h07, 8'hFE, 1'b1, 0, 0, 1'b1);
        run_op("dz55", 8'h55, 8'h00, 1'b0, 0, 0, 1'b1);
        run_op("after_dz", 8'd9, 8'd3, 1'b0, 0, 0, 1'b1);
        run_op("s_dz", 8'hF0, 8'h00, 1'b1, 0, 0, 1'b1);
        run_op("s_min_m1", 8'h80, 8'hFF, 1'b1, 0, 0, 1'b1);
        run_op("u_80_ff", 8'h80, 8'hFF, 1'b0, 0, 0, 1'b1);
        run_op("ena_stall", 8'd200, 8'd13, 1'b0, 3, 3, 1'b1);

        // start held through busy with changing operands; only the first op counts
        model(8'd77, 8'd5, 1'b0, eq, er, edz, eov);
        @(negedge clk);
        dividend = 8'd77; divisor = 8'd5; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'd3; divisor = 8'd1;
        n = 0;
        while (n < 60 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (done) start = 1'b0;
        end
        start = 1'b0;
        check("hold_start_latency", 32'(n), 32'(W + 1));
        check("hold_start_q", 32'(quotient), 32'(eq));
        check("hold_start_r", 32'(remainder), 32'(er));
        repeat (12) @(posedge clk);
        #1;

        // reset asserted for edge E4 of an op aborts it with no done pulse
        @(negedge clk);
        dividend = 8'd250; divisor = 8'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_q", 32'(quotient), 32'd0);
        check("abort_r", 32'(remainder), 32'd0);
        check("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | done | busy;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_op("post_abort", 8'd250, 8'd3, 1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = '1;
                2: ra = 8'h80;
                3: rb = 8'd1;
                default: ;
            endcase
            run_op("rand", ra, rb, rs, 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
